// File: rtl/updown_mod_counter_pkg.sv
// Shared Viterbi counter constants: direction encodings and bound-handling modes.
// Pure constants; no latency and no flow control.
package viterbi_pkg;

  localparam logic CNT_UP   = 1'b0;
  localparam logic CNT_DOWN = 1'b1;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : viterbi_pkg

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for the up/down modulo counter; master drives control, slave returns count.
// Plain wires; no latency and no handshake.
interface updown_mod_counter_if #(
  parameter int WIDTH = 6
);

  logic             enable;
  logic             d;
  logic             sclr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output enable, d, sclr, load, load_val,
    input  q, tc, ovf
  );

  modport slave (
    input  enable, d, sclr, load, load_val,
    output q, tc, ovf
  );

endinterface : updown_mod_counter_if

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with sync clear/load, wrap or saturate, terminal count and sticky overflow.
// q/ovf update one clk after sampling; tc is combinational; no backpressure (steps every enabled clk).
module updown_mod_counter
  import viterbi_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_mod_counter_if.slave  cnt
);

  if (WIDTH < 2 || WIDTH > 16 || MAX_COUNT < 0 || MAX_COUNT > 2**WIDTH-1) begin : g_param_err
    $error("updown_mod_counter: illegal WIDTH=%0d / MAX_COUNT=%0d", WIDTH, MAX_COUNT);
  end

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_Q};
  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;

  // One extra bit so the step past either bound is visible as a carry/borrow.
  logic [WIDTH:0] up_ext;
  logic [WIDTH:0] dn_ext;
  logic           up_past;
  logic           dn_past;

  assign up_ext  = {1'b0, q_q} + ONE_EXT;
  assign dn_ext  = {1'b0, q_q} - ONE_EXT;
  assign up_past = (up_ext > MAX_EXT);
  assign dn_past = dn_ext[WIDTH];

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (cnt.sclr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (cnt.load) begin
      q_d   = (cnt.load_val > MAX_Q) ? MAX_Q : cnt.load_val;
      ovf_d = 1'b0;
    end else if (cnt.enable) begin
      if (cnt.d == CNT_UP) begin
        if (up_past) begin
          q_d   = (SATURATE == MODE_SAT) ? q_q : '0;
          ovf_d = 1'b1;
        end else begin
          q_d = up_ext[WIDTH-1:0];
        end
      end else begin
        if (dn_past) begin
          q_d   = (SATURATE == MODE_SAT) ? q_q : MAX_Q;
          ovf_d = 1'b1;
        end else begin
          q_d = dn_ext[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt.q   = q_q;
  assign cnt.ovf = ovf_q;
  assign cnt.tc  = cnt.enable & (((cnt.d == CNT_UP)   & (q_q == MAX_Q)) |
                                 ((cnt.d == CNT_DOWN) & (q_q == '0)));

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Directed bench: three counter configurations (63 wrap, 47 saturate, 47 wrap) sharing clock and reset.
module tb_updown_mod_counter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(6)) ia ();
  updown_mod_counter_if #(.WIDTH(6)) ib ();
  updown_mod_counter_if #(.WIDTH(6)) ic ();

  updown_mod_counter #(.WIDTH(6), .MAX_COUNT(63), .SATURATE(0)) u_a (.clk(clk), .reset(rst_n), .cnt(ia));
  updown_mod_counter #(.WIDTH(6), .MAX_COUNT(47), .SATURATE(1)) u_b (.clk(clk), .reset(rst_n), .cnt(ib));
  updown_mod_counter #(.WIDTH(6), .MAX_COUNT(47), .SATURATE(0)) u_c (.clk(clk), .reset(rst_n), .cnt(ic));

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ia.enable = 0; ia.d = 0; ia.sclr = 0; ia.load = 0; ia.load_val = '0;
    ib.enable = 0; ib.d = 0; ib.sclr = 0; ib.load = 0; ib.load_val = '0;
    ic.enable = 0; ic.d = 0; ic.sclr = 0; ic.load = 0; ic.load_val = '0;

    // Reset state
    #3;
    chk("rst_q_a", int'(ia.q), 0);
    chk("rst_ovf_a", int'(ia.ovf), 0);
    chk("rst_tc_a", int'(ia.tc), 0);
    chk("rst_q_b", int'(ib.q), 0);
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    step();

    // 1: async reset mid-count, then count 1,2,3
    ia.load = 1; ia.load_val = 6'd20;
    step();
    chk("t1_load20", int'(ia.q), 20);
    ia.load = 0; ia.enable = 1; ia.d = 0;
    step(); step(); step();
    chk("t1_q23", int'(ia.q), 23);
    rst_n = 1'b0;
    #2;
    chk("t1_async_q", int'(ia.q), 0);
    chk("t1_async_ovf", int'(ia.ovf), 0);
    @(negedge clk) rst_n = 1'b1;
    step(); chk("t1_cnt1", int'(ia.q), 1);
    step(); chk("t1_cnt2", int'(ia.q), 2);
    step(); chk("t1_cnt3", int'(ia.q), 3);

    // 2: wrap at 63
    ia.enable = 0; ia.load = 1; ia.load_val = 6'd62;
    step();
    chk("t2_load62", int'(ia.q), 62);
    ia.load = 0; ia.enable = 1; ia.d = 0;
    #1;
    chk("t2_tc_at62", int'(ia.tc), 0);
    step();
    chk("t2_q63", int'(ia.q), 63);
    chk("t2_tc63", int'(ia.tc), 1);
    chk("t2_ovf_pre", int'(ia.ovf), 0);
    step();
    chk("t2_wrap0", int'(ia.q), 0);
    chk("t2_ovf_set", int'(ia.ovf), 1);
    step();
    chk("t2_q1", int'(ia.q), 1);
    chk("t2_ovf_sticky", int'(ia.ovf), 1);

    // sclr alone clears sticky ovf
    ia.enable = 0; ia.sclr = 1;
    step();
    chk("sclr_q", int'(ia.q), 0);
    chk("sclr_ovf", int'(ia.ovf), 0);
    ia.sclr = 0;

    // 5: priority sclr > load > enable
    ia.load = 1; ia.load_val = 6'd10;
    step();
    chk("t5_load10", int'(ia.q), 10);
    ia.sclr = 1; ia.load = 1; ia.load_val = 6'd5; ia.enable = 1; ia.d = 0;
    step();
    chk("t5_sclr_wins", int'(ia.q), 0);
    ia.sclr = 0; ia.enable = 0; ia.load_val = 6'd10;
    step();
    chk("t5_reload10", int'(ia.q), 10);
    ia.load_val = 6'd5; ia.enable = 1;
    step();
    chk("t5_load_wins", int'(ia.q), 5);
    ia.load = 0; ia.enable = 0;

    // 6: hold with enable low while d toggles
    ia.load = 1; ia.load_val = 6'd17;
    step();
    ia.load = 0;
    for (int i = 0; i < 4; i++) begin
      ia.d = i[0];
      #1;
      chk("t6_tc", int'(ia.tc), 0);
      step();
      chk("t6_hold", int'(ia.q), 17);
    end

    // 3: saturate at 0 with MAX=47
    ib.load = 1; ib.load_val = 6'd1;
    step();
    chk("t3_load1", int'(ib.q), 1);
    ib.load = 0; ib.enable = 1; ib.d = 1;
    step();
    chk("t3_q0", int'(ib.q), 0);
    chk("t3_tc", int'(ib.tc), 1);
    chk("t3_ovf_pre", int'(ib.ovf), 0);
    step();
    chk("t3_hold0a", int'(ib.q), 0);
    step();
    chk("t3_hold0b", int'(ib.q), 0);
    chk("t3_ovf", int'(ib.ovf), 1);
    ib.d = 0;
    step();
    chk("t3_up1", int'(ib.q), 1);
    chk("t3_ovf_sticky", int'(ib.ovf), 1);
    ib.enable = 0; ib.load = 1; ib.load_val = 6'd47;
    step();
    ib.load = 0; ib.enable = 1;
    step();
    chk("t3_sat47", int'(ib.q), 47);
    chk("t3_sat_ovf", int'(ib.ovf), 1);
    ib.enable = 0;

    // 4: wrap down to 47, load clamp
    ic.sclr = 1;
    step();
    ic.sclr = 0; ic.enable = 1; ic.d = 1;
    step();
    chk("t4_wrap47", int'(ic.q), 47);
    chk("t4_ovf", int'(ic.ovf), 1);
    ic.enable = 0; ic.load = 1; ic.load_val = 6'd60;
    step();
    chk("t4_clamp", int'(ic.q), 47);
    chk("t4_load_ovf", int'(ic.ovf), 0);
    ic.load = 0; ic.enable = 1; ic.d = 0;
    #1;
    chk("t4_tc_up", int'(ic.tc), 1);
    step();
    chk("t4_wrap_up", int'(ic.q), 0);
    chk("t4_ovf_up", int'(ic.ovf), 1);
    ic.enable = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_updown_mod_counter
